uart_tx_frame: RTL

//  - Serialises one parallel byte per valid/ready handshake into an asynchronous UART frame on tx_out.
//  - Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
//  - Transmit-side counterpart of the UART receive path; the idle line is high.
//  - The far-end receiver detects the start of a frame on the falling edge of tx_out.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_gen.sv | 39 +++
 rtl/uart_tx_frame.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, line level and defaults.
// The receive path imports this package as well.
package uart_pkg;

  // Transmit FSM state encoding (3-bit)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // 100 MHz clock, 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  // Idle (mark) level of the serial line
  localparam logic LINE_IDLE = 1'b1;

  // Parity over the low nbits of data; odd selects odd parity sense.
  function automatic logic parity_bit(input logic [8:0] data, input int nbits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) begin
        p = p ^ data[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// A clear restarts the period so a new bit always lasts a full period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign bit_tick = (cnt_reg == CNT_LAST);

  // Next count: wrap on terminal count, restart on clear
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (clear || bit_tick) begin
      cnt_next = '0;
    end
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one word per valid/ready handshake and sends
// start, LSB-first data, optional parity and stop bits on a registered line.
// tx_out is registered from the current state, so the line lags the FSM by
// one clock; this gives exactly one extra idle-high clock between frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  tx_state_t            state_reg,   state_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg,   shift_next;
  logic [DATA_BITS-1:0] data_reg,    data_next;
  logic                 tx_out_reg,  tx_out_next;
  logic                 done_reg,    done_next;

  logic                 bit_tick;
  logic                 handshake;
  logic                 state_change;
  logic                 parity_val;
  logic [DATA_BITS-1:0] shifted;
  logic [8:0]           data_wide;

  // Ready is forced low while reset is held so nothing is accepted then
  assign tx_ready     = (state_reg == ST_IDLE) && !reset;
  assign handshake    = tx_valid && tx_ready;
  assign tx_busy      = (state_reg != ST_IDLE);
  assign tx_out       = tx_out_reg;
  assign tx_done      = done_reg;
  assign state_change = (state_next != state_reg);

  // Parity comes from the copy latched at the handshake, not live tx_data
  assign data_wide  = 9'(data_reg);
  assign parity_val = parity_bit(data_wide, DATA_BITS, PAR_ODD);

  // Right shift of the transmit register, zero filled at the MSB
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      if (gi == DATA_BITS - 1) begin : g_msb
        assign shifted[gi] = 1'b0;
      end else begin : g_low
        assign shifted[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  // Bit timer restarts on the handshake and on every state change
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_change),
    .bit_tick(bit_tick)
  );

  // Next-state, line level and datapath updates
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    tx_out_next  = LINE_IDLE;
    done_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        tx_out_next = LINE_IDLE;
        if (handshake) begin
          state_next = ST_START;
          shift_next = tx_data;
          data_next  = tx_data;
        end
      end
      ST_START: begin
        tx_out_next = 1'b0;
        if (bit_tick) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_out_next = shift_reg[0];
        if (bit_tick) begin
          shift_next = shifted;
          if (bit_cnt_reg == LAST_DATA) begin
            state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_out_next = parity_val;
        if (bit_tick) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_out_next = LINE_IDLE;
        if (bit_tick) begin
          if (bit_cnt_reg == LAST_STOP) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (state_next != state_reg) begin
      bit_cnt_next = '0;
    end
  end

  // State, counters, shift register and registered line output
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      tx_out_reg  <= LINE_IDLE;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      tx_out_reg  <= tx_out_next;
      done_reg    <= done_next;
    end
  end

endmodule
